// File: rtl/csa3_pkg.sv
// Shared helpers for the pipelined three-operand adder: segment width and placement.
package csa3_pkg;

  function automatic int unsigned seg_w(input int unsigned r, input int unsigned segs);
    return (r + segs - 1) / segs;
  endfunction

  function automatic int unsigned seg_lo(input int unsigned k, input int unsigned segw);
    return k * segw;
  endfunction

endpackage

// File: rtl/cpa_seg.sv
// Ripple carry-propagate adder over one pipeline segment, built from full-adder cells.
module cpa_seg #(
  parameter int unsigned Width = 1
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             cin_i,
  output logic [Width-1:0] sum_o,
  output logic             cout_o
);

  logic [Width:0] cy;

  assign cy[0] = cin_i;

  for (genvar i = 0; i < Width; i++) begin : g_bit
    fa u_fa (
      .a_i  (a_i[i]),
      .b_i  (b_i[i]),
      .c_i  (cy[i]),
      .s_o  (sum_o[i]),
      .co_o (cy[i+1])
    );
  end

  assign cout_o = cy[Width];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell, used for both the carry-save row and the ripple segments.
module fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa3_pipe_add.sv
// Pipelined x + y +/- z: one carry-save row, then a carry-propagate adder split into SEGS
// registered segments with valid/ready flow control and a tag riding alongside.
module csa3_pipe_add
  import csa3_pkg::*;
#(
  parameter int unsigned W    = 26,
  parameter int unsigned SEGS = 2,
  parameter int unsigned TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    x,
  input  logic [W-1:0]    y,
  input  logic [W-1:0]    z,
  input  logic            sub,
  input  logic [TAGW-1:0] tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W+1:0]    result,
  output logic [TAGW-1:0] out_tag
);

  localparam int unsigned R    = W + 2;
  localparam int unsigned SegW = seg_w(R, SEGS);

  logic [R-1:0] xe, ye, zp, csa_s, csa_maj, csa_c;
  logic         accept;

  assign xe = R'(x);
  assign ye = R'(y);
  assign zp = sub ? ~R'(z) : R'(z);

  for (genvar i = 0; i < R; i++) begin : g_csa
    fa u_csa_fa (
      .a_i  (xe[i]),
      .b_i  (ye[i]),
      .c_i  (zp[i]),
      .s_o  (csa_s[i]),
      .co_o (csa_maj[i])
    );
  end

  // The subtract carry-in rides in the empty bit 0 of the shifted carry vector.
  assign csa_c = {csa_maj[R-2:0], sub};

  // Stage registers: finished low bits (sum), pending s/c vectors, inter-segment carry.
  logic [SEGS-1:0] valid_q, cry_q, adv;
  logic [R-1:0]    sum_q [SEGS];
  logic [R-1:0]    s_q   [SEGS];
  logic [R-1:0]    c_q   [SEGS];
  logic [TAGW-1:0] tag_q [SEGS];

  logic [SEGS-1:0] src_valid, src_cin, cry_d;
  logic [R-1:0]    src_s   [SEGS];
  logic [R-1:0]    src_c   [SEGS];
  logic [R-1:0]    src_sum [SEGS];
  logic [R-1:0]    sum_d   [SEGS];
  logic [TAGW-1:0] src_tag [SEGS];

  // Stage k advances unless it and every stage after it are full and the output is held.
  always_comb begin
    logic full;
    adv = '0;
    for (int k = 0; k < SEGS; k++) begin
      full = 1'b1;
      for (int j = k; j < SEGS; j++) begin
        full = full & valid_q[j];
      end
      adv[k] = out_ready | ~full;
    end
  end

  assign in_ready = adv[0];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < SEGS; k++) begin : g_stage
    localparam int unsigned Lo  = seg_lo(k, SegW);
    localparam bit          Has = (Lo < R);
    localparam int unsigned Hi  = (Lo + SegW > R) ? R : Lo + SegW;
    localparam int unsigned Wd  = Has ? Hi - Lo : 1;

    if (k == 0) begin : g_first
      assign src_valid[k] = accept;
      assign src_s[k]     = csa_s;
      assign src_c[k]     = csa_c;
      assign src_sum[k]   = '0;
      assign src_cin[k]   = 1'b0;
      assign src_tag[k]   = tag;
    end else begin : g_next
      assign src_valid[k] = valid_q[k-1];
      assign src_s[k]     = s_q[k-1];
      assign src_c[k]     = c_q[k-1];
      assign src_sum[k]   = sum_q[k-1];
      assign src_cin[k]   = cry_q[k-1];
      assign src_tag[k]   = tag_q[k-1];
    end

    if (Has) begin : g_seg
      localparam logic [R-1:0] Mask = ((R'(1) << Wd) - R'(1)) << Lo;
      logic [Wd-1:0] seg_sum;
      logic          seg_cout;

      cpa_seg #(
        .Width (Wd)
      ) u_cpa_seg (
        .a_i    (src_s[k][Lo +: Wd]),
        .b_i    (src_c[k][Lo +: Wd]),
        .cin_i  (src_cin[k]),
        .sum_o  (seg_sum),
        .cout_o (seg_cout)
      );

      assign sum_d[k] = (src_sum[k] & ~Mask) | (R'(seg_sum) << Lo);
      assign cry_d[k] = seg_cout;
    end else begin : g_empty
      // Deep pipelines can leave trailing segments with no bits; they only delay.
      assign sum_d[k] = src_sum[k];
      assign cry_d[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cry_q   <= '0;
      for (int k = 0; k < SEGS; k++) begin
        sum_q[k] <= '0;
        s_q[k]   <= '0;
        c_q[k]   <= '0;
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < SEGS; k++) begin
        if (adv[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) begin
            sum_q[k] <= sum_d[k];
            s_q[k]   <= src_s[k];
            c_q[k]   <= src_c[k];
            cry_q[k] <= cry_d[k];
            tag_q[k] <= src_tag[k];
          end
        end
      end
    end
  end

  assign out_valid = valid_q[SEGS-1];
  assign result    = sum_q[SEGS-1];
  assign out_tag   = tag_q[SEGS-1];

  // Top CSA carry and final-segment carry fall off the mod-2^R result.
  logic unused_tail;
  assign unused_tail = ^{s_q[SEGS-1], c_q[SEGS-1], cry_q[SEGS-1], csa_maj[R-1]};

endmodule

// File: tb/tb_csa3_pipe_add.sv
// Scoreboard bench for csa3_pipe_add: directed sums, segment-depth variants, backpressure,
// random throughput and mid-flight reset.
module tb_csa3_pipe_add;

  localparam int unsigned W    = 26;
  localparam int unsigned SEGS = 2;

  typedef struct packed {
    logic [27:0] res;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, sub, aux_valid;
  logic [25:0] x, y, z;
  logic [3:0]  tag;
  logic        in_ready, out_valid;
  logic [27:0] result;
  logic [3:0]  out_tag;

  logic [2:0]  aux_ir, aux_ov;
  logic [27:0] aux_res [3];
  logic [3:0]  aux_tag [3];

  exp_t        q[$];
  exp_t        e;
  int          n_cmp = 0;
  int          n_err = 0;
  int          stalls = 0;
  logic        held = 1'b0;
  logic [27:0] held_res;
  logic [3:0]  held_tag;

  always #5 clk = ~clk;

  csa3_pipe_add #(
    .W    (W),
    .SEGS (SEGS),
    .TAGW (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .z         (z),
    .sub       (sub),
    .tag       (tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_tag   (out_tag)
  );

  for (genvar i = 0; i < 3; i++) begin : g_aux
    csa3_pipe_add #(
      .W    (W),
      .SEGS (i == 0 ? 1 : (i == 1 ? 4 : 28)),
      .TAGW (4)
    ) u_aux (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (aux_valid),
      .in_ready  (aux_ir[i]),
      .x         (x),
      .y         (y),
      .z         (z),
      .sub       (sub),
      .tag       (tag),
      .out_valid (aux_ov[i]),
      .out_ready (1'b1),
      .result    (aux_res[i]),
      .out_tag   (aux_tag[i])
    );
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [27:0] ref_sum(input logic [25:0] a, input logic [25:0] b,
                                          input logic [25:0] c, input logic s);
    logic [27:0] t;
    t = {2'b00, a} + {2'b00, b};
    if (s) t = t - {2'b00, c};
    else   t = t + {2'b00, c};
    return t;
  endfunction

  task automatic send(input logic [25:0] a, input logic [25:0] b, input logic [25:0] c,
                      input logic s, input logic [3:0] t, input logic [27:0] exp);
    int waits = 0;
    @(negedge clk);
    x = a; y = b; z = c; sub = s; tag = t; in_valid = 1'b1;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) begin
      check("send_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    q.push_back('{res: exp, tag: t});
    stalls += waits;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    #5;
    check("drain", q.size(), 0);
  endtask

  // Output monitor: sampled mid-low-phase, after all bench drives have settled.
  always begin
    @(negedge clk);
    #3;
    if (rst) begin
      held = 1'b0;
    end else if (out_valid && out_ready) begin
      held = 1'b0;
      if (q.size() == 0) begin
        check("spurious_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        check("result", result, e.res);
        check("out_tag", out_tag, e.tag);
      end
    end else if (out_valid) begin
      if (held) begin
        check("stall_result", result, held_res);
        check("stall_tag", out_tag, held_tag);
      end
      held     = 1'b1;
      held_res = result;
      held_tag = out_tag;
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  got;
    logic [25:0] ra, rb, rc;
    logic        rs;

    rst = 1'b1; in_valid = 1'b0; aux_valid = 1'b0; out_ready = 1'b1;
    x = '0; y = '0; z = '0; sub = 1'b0; tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);

    // Directed sums, including the bit-13/14 segment boundary.
    send(26'h3FFFFFF, 26'h3FFFFFF, 26'h3FFFFFF, 1'b0, 4'd5, 28'hBFFFFFD);
    send(26'd5, 26'd0, 26'd7, 1'b1, 4'd1, 28'hFFFFFFE);
    send(26'h3FFFFFF, 26'h3FFFFFF, 26'd0, 1'b1, 4'd2, 28'h7FFFFFE);
    send(26'h0003FFF, 26'd1, 26'd0, 1'b0, 4'd3, 28'h0004000);
    drain();

    // Same boundary operands through SEGS = 1, 4, 28.
    @(negedge clk);
    for (int i = 0; i < 3; i++) check("aux_in_ready", aux_ir[i], 1);
    x = 26'h0003FFF; y = 26'd1; z = 26'd0; sub = 1'b0; tag = 4'hA; aux_valid = 1'b1;
    @(posedge clk);
    #1 aux_valid = 1'b0;
    got = '0;
    repeat (40) begin
      @(negedge clk);
      #3;
      for (int i = 0; i < 3; i++) begin
        if (aux_ov[i] && !got[i]) begin
          got[i] = 1'b1;
          check("aux_result", aux_res[i], 28'h0004000);
          check("aux_tag", aux_tag[i], 4'hA);
        end
      end
    end
    for (int i = 0; i < 3; i++) check("aux_seen", got[i], 1);

    // Backpressure: six ops into a held output.
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          ra = 26'($urandom); rb = 26'($urandom); rc = 26'($urandom); rs = 1'($urandom);
          send(ra, rb, rc, rs, 4'(i), ref_sum(ra, rb, rc, rs));
        end
      end
      begin
        repeat (3) @(negedge clk);
        #2 check("bp_in_ready", in_ready, 0);
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();

    // Throughput: 100 back-to-back ops with the consumer always ready.
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      ra = 26'($urandom); rb = 26'($urandom); rc = 26'($urandom); rs = 1'($urandom);
      send(ra, rb, rc, rs, 4'(i), ref_sum(ra, rb, rc, rs));
    end
    repeat (SEGS - 1) @(posedge clk);
    @(negedge clk);
    #5;
    check("tput_stalls", stalls, 0);
    check("tput_latency", q.size(), 0);
    drain();

    // Reset with two operations in flight.
    @(negedge clk);
    out_ready = 1'b0;
    send(26'd100, 26'd200, 26'd50, 1'b0, 4'd7, 28'd350);
    send(26'd9, 26'd9, 26'd9, 1'b1, 4'd8, 28'd9);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_in_ready", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_idle", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
